sbqm_multi_teller: RTL and testbench
====================================

Name: sbqm_multi_teller

Overview:
Parametrised queue manager for the bank queue; successor to the fixed 3-bit/ROM-based queue manager. It counts customers from entry/exit photocell beams with synchronisation and falling-edge detection, and reports full/empty status. It rejects illegal enter/leave events, and computes expected waiting time arithmetically with a sequential divider instead of a lookup table. It sits between the photocell inputs and the display/controller logic.

Parameters:
CNT_W, 3, width of p_count
MAX_COUNT, 7, queue capacity; must be at most 2**CNT_W-1
TELLER_W, 2, width of t_count
SERVICE_T, 3, service time per customer, in time units
WT_W, 8, width of waiting_time and of the divider datapath; SERVICE_T*(MAX_COUNT+2**TELLER_W-2) must be less than 2**WT_W

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
entering_cell  in  1  entry beam; 1 = clear, 0 = blocked
leaving_cell  in  1  exit beam; 1 = clear, 0 = blocked
t_count  in  TELLER_W  number of open tellers; 0 is treated as 1
p_count  out  CNT_W  customers currently in the queue
full_flag  out  1  high when p_count == MAX_COUNT
empty_flag  out  1  high when p_count == 0
enter_reject  out  1  one-cycle pulse: entry event dropped because the queue is full
leave_reject  out  1  one-cycle pulse: exit event dropped because the queue is empty
waiting_time  out  WT_W  expected wait, SERVICE_T*(p+t-1)/t, floored
wt_valid  out  1  high when waiting_time matches the current p_count/t_count

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Every flop, including the synchroniser flops, is reset only on a rising clock edge while reset=1.
- Reset values:
  - p_count=0, empty_flag=1, full_flag=0
  - enter_reject=0, leave_reject=0
  - waiting_time=0, wt_valid=1
  - FSM in IDLE; operand snapshot p=0, t=1
  - synchroniser flops s1/s2/s3 = 1, so no spurious edge is seen after reset
- Edge detection, per cell: s1<=cell, s2<=s1, s3<=s2. Event ev = s3 & ~s2 (a 1->0 transition, i.e. a beam blocked).
  - If the cell is first sampled low at edge E0, ev is high for one cycle after E1 and acts at edge E2.
  - A beam held low produces exactly one event. The rising (unblock) edge produces none.
- Counter update, at each edge with ev_in/ev_out:
  - ev_in only, not full: p_count+1.
  - ev_in only, full: p_count unchanged, enter_reject=1 for one cycle.
  - ev_out only, not empty: p_count-1.
  - ev_out only, empty: p_count unchanged, leave_reject=1 for one cycle.
  - Both events together: p_count unchanged, no reject, even when full or empty.
  - full_flag and empty_flag are decoded from the p_count register and are valid in the same cycle as p_count.
- Effective teller count t_eff = (t_count==0) ? 1 : t_count.
- Waiting-time FSM states are IDLE, ZERO and CALC.
  - IDLE: holds the result with wt_valid=1.
  - Leaving IDLE: at the first edge where {p_count, t_eff} differs from the snapshot, latch the new snapshot and set wt_valid<=0. Go to ZERO if the snapshot p==0, otherwise CALC.
  - ZERO: next edge sets waiting_time<=0, wt_valid<=1, back to IDLE.
  - CALC: restoring divider on numerator N=SERVICE_T*(p+t_eff-1) and divisor t_eff, one quotient bit per edge, WT_W edges. The last edge writes the quotient to waiting_time, sets wt_valid<=1 and returns to IDLE.
  - Operand change during ZERO or CALC: restart at the next edge with a new snapshot. No result is written for the abandoned operands.
  - waiting_time holds its previous value while wt_valid=0.
- Latency from a p_count or t_eff change to wt_valid=1 is WT_W+1 edges (2 edges when p=0).
- Reset asserted mid-CALC aborts the calculation and forces all reset values.

Optional Feature:
SBQM_REJECT_CNT_EN
- Defined: adds two outputs, rej_enter_cnt[7:0] and rej_leave_cnt[7:0].
  - Each increments at every enter_reject or leave_reject pulse respectively.
  - Each saturates at 255.
  - Both reset to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then hold both cells at 1 for 20 cycles -> p_count=0, empty_flag=1, full_flag=0, wt_valid=1, waiting_time=0, no reject pulses.
- t_count=1; 3 entry blocks (each cell low for 2 cycles) -> p_count=3 with each increment 2 edges after the first low sample; wt_valid falls, then waiting_time=9 after 9 edges.
- With p_count=3, change t_count to 2 -> waiting_time=6 (3*4/2). Then set t_count=0 -> behaves as t=1, waiting_time=9.
- 8 entry blocks from empty, MAX_COUNT=7, t_count=3 -> p_count saturates at 7, full_flag=1, exactly one enter_reject pulse, waiting_time=9. Drive simultaneous entry and exit blocks -> p_count stays 7, no reject.
- Drain to 0, then one extra exit block -> p_count=0, empty_flag=1, one leave_reject pulse, waiting_time=0 two edges after the last decrement. With SBQM_REJECT_CNT_EN defined, rej_leave_cnt=1.
- Change t_count every 3 cycles during CALC, then hold; also assert reset mid-CALC -> only the final operands produce a result; after reset, all outputs return to their reset values.

Source files
------------

// File: rtl/sbqm_multi_teller_if.sv
// Photocell/status bundle for the bank-queue manager.
// Optional reject counters appear when SBQM_REJECT_CNT_EN is defined.
interface sbqm_multi_teller_if #(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned TELLER_W = 2,
  parameter int unsigned WT_W     = 8
);
  logic                entering_cell;
  logic                leaving_cell;
  logic [TELLER_W-1:0] t_count;
  logic [CNT_W-1:0]    p_count;
  logic                full_flag;
  logic                empty_flag;
  logic                enter_reject;
  logic                leave_reject;
  logic [WT_W-1:0]     waiting_time;
  logic                wt_valid;
`ifdef SBQM_REJECT_CNT_EN
  logic [7:0]          rej_enter_cnt;
  logic [7:0]          rej_leave_cnt;

  modport master (output entering_cell, leaving_cell, t_count,
                  input  p_count, full_flag, empty_flag, enter_reject, leave_reject,
                         waiting_time, wt_valid, rej_enter_cnt, rej_leave_cnt);
  modport slave  (input  entering_cell, leaving_cell, t_count,
                  output p_count, full_flag, empty_flag, enter_reject, leave_reject,
                         waiting_time, wt_valid, rej_enter_cnt, rej_leave_cnt);
`else
  modport master (output entering_cell, leaving_cell, t_count,
                  input  p_count, full_flag, empty_flag, enter_reject, leave_reject,
                         waiting_time, wt_valid);
  modport slave  (input  entering_cell, leaving_cell, t_count,
                  output p_count, full_flag, empty_flag, enter_reject, leave_reject,
                         waiting_time, wt_valid);
`endif
endinterface

// File: rtl/sbqm_multi_teller.sv
// Bank queue manager: photocell edge counting plus expected wait via a restoring divider.
// Optional saturating reject counters are built when SBQM_REJECT_CNT_EN is defined.
module sbqm_multi_teller #(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned MAX_COUNT = 7,
  parameter int unsigned TELLER_W  = 2,
  parameter int unsigned SERVICE_T = 3,
  parameter int unsigned WT_W      = 8
) (
  input logic              clock,
  input logic              reset,
  sbqm_multi_teller_if.slave bus
);

  localparam int unsigned STEP_W  = $clog2(WT_W + 1);
  localparam int unsigned TRIAL_W = WT_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] CALC = 2'd2;

  logic [2:0]          sync_in, sync_out;
  logic                ev_in_c, ev_out_c;
  logic [CNT_W-1:0]    p_count, p_next_c;
  logic                full_flag, empty_flag, enter_reject, leave_reject;
  logic                enter_rej_c, leave_rej_c;

  logic [1:0]          state, state_nx;
  logic [CNT_W-1:0]    snap_p, snap_p_nx;
  logic [TELLER_W-1:0] snap_t, snap_t_nx;
  logic [WT_W-1:0]     quo, quo_nx, rem, rem_nx;
  logic [STEP_W-1:0]   step, step_nx;
  logic [WT_W-1:0]     waiting_time, wt_nx;
  logic                wt_valid, wt_valid_nx;
  logic [TELLER_W-1:0] t_eff_c;
  logic [WT_W-1:0]     num_c, diff_c;
  logic [TRIAL_W-1:0]  trial_c;
  logic                q_bit_c, op_change_c;

  // Three-stage synchronisers, preset high so reset never looks like a blocked beam
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_in  <= '1;
      sync_out <= '1;
    end else begin
      sync_in  <= {sync_in[1:0], bus.entering_cell};
      sync_out <= {sync_out[1:0], bus.leaving_cell};
    end
  end

  assign ev_in_c  = sync_in[2] & ~sync_in[1];
  assign ev_out_c = sync_out[2] & ~sync_out[1];

  // Simultaneous entry and exit cancel out, even at the capacity limits
  always_comb begin
    p_next_c    = p_count;
    enter_rej_c = 1'b0;
    leave_rej_c = 1'b0;
    if (ev_in_c && !ev_out_c) begin
      if (p_count == CNT_W'(MAX_COUNT)) enter_rej_c = 1'b1;
      else                              p_next_c    = p_count + CNT_W'(1);
    end else if (ev_out_c && !ev_in_c) begin
      if (p_count == '0) leave_rej_c = 1'b1;
      else               p_next_c    = p_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_count      <= '0;
      full_flag    <= 1'b0;
      empty_flag   <= 1'b1;
      enter_reject <= 1'b0;
      leave_reject <= 1'b0;
    end else begin
      p_count      <= p_next_c;
      full_flag    <= (p_next_c == CNT_W'(MAX_COUNT));
      empty_flag   <= (p_next_c == '0);
      enter_reject <= enter_rej_c;
      leave_reject <= leave_rej_c;
    end
  end

`ifdef SBQM_REJECT_CNT_EN
  logic [7:0] rej_enter_cnt, rej_leave_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rej_enter_cnt <= '0;
      rej_leave_cnt <= '0;
    end else begin
      if (enter_rej_c && rej_enter_cnt != 8'hFF) rej_enter_cnt <= rej_enter_cnt + 8'd1;
      if (leave_rej_c && rej_leave_cnt != 8'hFF) rej_leave_cnt <= rej_leave_cnt + 8'd1;
    end
  end

  assign bus.rej_enter_cnt = rej_enter_cnt;
  assign bus.rej_leave_cnt = rej_leave_cnt;
`endif

  assign t_eff_c     = (bus.t_count == '0) ? TELLER_W'(1) : bus.t_count;
  assign op_change_c = {p_count, t_eff_c} != {snap_p, snap_t};
  assign num_c       = WT_W'(SERVICE_T) * (WT_W'(p_count) + WT_W'(t_eff_c) - WT_W'(1));

  // One restoring step: shift the next numerator bit into the partial remainder
  assign trial_c = {rem, quo[WT_W-1]};
  assign q_bit_c = trial_c >= TRIAL_W'(snap_t);
  assign diff_c  = WT_W'(trial_c - TRIAL_W'(snap_t));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      snap_p       <= '0;
      snap_t       <= TELLER_W'(1);
      quo          <= '0;
      rem          <= '0;
      step         <= '0;
      waiting_time <= '0;
      wt_valid     <= 1'b1;
    end else begin
      state        <= state_nx;
      snap_p       <= snap_p_nx;
      snap_t       <= snap_t_nx;
      quo          <= quo_nx;
      rem          <= rem_nx;
      step         <= step_nx;
      waiting_time <= wt_nx;
      wt_valid     <= wt_valid_nx;
    end
  end

  // Any operand change, in any state, restarts from a fresh snapshot
  always_comb begin
    state_nx    = state;
    snap_p_nx   = snap_p;
    snap_t_nx   = snap_t;
    quo_nx      = quo;
    rem_nx      = rem;
    step_nx     = step;
    wt_nx       = waiting_time;
    wt_valid_nx = wt_valid;
    if (op_change_c) begin
      snap_p_nx   = p_count;
      snap_t_nx   = t_eff_c;
      quo_nx      = num_c;
      rem_nx      = '0;
      step_nx     = '0;
      wt_valid_nx = 1'b0;
      state_nx    = (p_count == '0) ? ZERO : CALC;
    end else begin
      case (state)
        ZERO: begin
          wt_nx       = '0;
          wt_valid_nx = 1'b1;
          state_nx    = IDLE;
        end
        CALC: begin
          rem_nx  = q_bit_c ? diff_c : trial_c[WT_W-1:0];
          quo_nx  = {quo[WT_W-2:0], q_bit_c};
          step_nx = step + STEP_W'(1);
          if (step == STEP_W'(WT_W - 1)) begin
            wt_nx       = {quo[WT_W-2:0], q_bit_c};
            wt_valid_nx = 1'b1;
            state_nx    = IDLE;
          end
        end
        IDLE:    ;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.p_count      = p_count;
  assign bus.full_flag    = full_flag;
  assign bus.empty_flag   = empty_flag;
  assign bus.enter_reject = enter_reject;
  assign bus.leave_reject = leave_reject;
  assign bus.waiting_time = waiting_time;
  assign bus.wt_valid     = wt_valid;

endmodule

// File: tb/tb_sbqm_multi_teller.sv
// Directed bench for sbqm_multi_teller: counting, rejects, divider results and restarts.
// Reject-counter checks are included when SBQM_REJECT_CNT_EN is defined.
module tb_sbqm_multi_teller;

  localparam int unsigned SVC = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_erej = 0;
  int   n_lrej = 0;
  int   base_e, base_l;
  logic [31:0] sb[$];

  sbqm_multi_teller_if #(.CNT_W(3), .TELLER_W(2), .WT_W(8)) bus ();

  sbqm_multi_teller #(
    .CNT_W(3), .MAX_COUNT(7), .TELLER_W(2), .SERVICE_T(3), .WT_W(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Tally reject pulses as seen on the outputs
  always @(posedge clock) begin
    if (!reset) begin
      if (bus.enter_reject === 1'b1) n_erej++;
      if (bus.leave_reject === 1'b1) n_lrej++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wt_model(input int unsigned p, input int unsigned t);
    int unsigned te;
    te = (t == 0) ? 1 : t;
    return 32'((SVC * (p + te - 1)) / te);
  endfunction

  task automatic cell_pulse(input bit ent, input bit lv);
    bus.entering_cell = !ent;
    bus.leaving_cell  = !lv;
    step(2);
    bus.entering_cell = 1'b1;
    bus.leaving_cell  = 1'b1;
    step(2);
  endtask

  // Wait (bounded) for a settled result, then compare it with the oldest expectation
  task automatic wait_result(input string tag);
    int k;
    logic [31:0] exp;
    k = 0;
    while (bus.wt_valid !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.wt_valid), 32'd1);
    exp = sb.pop_front();
    chk(tag, 32'(bus.waiting_time), exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_p"},     32'(bus.p_count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty_flag), 32'd1);
    chk({tag, "_full"},  32'(bus.full_flag), 32'd0);
    chk({tag, "_erej"},  32'(bus.enter_reject), 32'd0);
    chk({tag, "_lrej"},  32'(bus.leave_reject), 32'd0);
    chk({tag, "_wt"},    32'(bus.waiting_time), 32'd0);
    chk({tag, "_wtv"},   32'(bus.wt_valid), 32'd1);
  endtask

  initial begin
    bus.entering_cell = 1'b1;
    bus.leaving_cell  = 1'b1;
    bus.t_count       = 2'd1;
    step(3);
    reset = 1'b0;
    chk_reset_state("rst");
    step(20);
    chk_reset_state("idle20");
    chk("idle_rej_cnt", 32'(n_erej + n_lrej), 32'd0);

    // First entry traced edge by edge: increment lands two edges after first low sample
    bus.entering_cell = 1'b0;
    step(1);
    chk("ent_e0", 32'(bus.p_count), 32'd0);
    step(1);
    chk("ent_e1", 32'(bus.p_count), 32'd0);
    bus.entering_cell = 1'b1;
    step(1);
    chk("ent_e2", 32'(bus.p_count), 32'd1);
    chk("ent_empty", 32'(bus.empty_flag), 32'd0);
    step(1);
    cell_pulse(1, 0);
    cell_pulse(1, 0);
    chk("p3", 32'(bus.p_count), 32'd3);
    chk("p3_wtv_low", 32'(bus.wt_valid), 32'd0);
    sb.push_back(wt_model(3, 1));
    wait_result("wt_p3_t1");

    // Teller change: result appears exactly 9 edges later, old value held meanwhile
    bus.t_count = 2'd2;
    step(8);
    chk("t2_wtv_e8", 32'(bus.wt_valid), 32'd0);
    chk("t2_hold", 32'(bus.waiting_time), 32'd9);
    step(1);
    chk("t2_wtv_e9", 32'(bus.wt_valid), 32'd1);
    sb.push_back(wt_model(3, 2));
    wait_result("wt_p3_t2");
    bus.t_count = 2'd0;
    sb.push_back(wt_model(3, 0));
    step(1);
    chk("t0_wtv_low", 32'(bus.wt_valid), 32'd0);
    wait_result("wt_p3_t0");

    // Drain, then overfill with three tellers
    repeat (3) cell_pulse(0, 1);
    chk("drain_p", 32'(bus.p_count), 32'd0);
    chk("drain_empty", 32'(bus.empty_flag), 32'd1);
    bus.t_count = 2'd3;
    base_e = n_erej;
    repeat (8) cell_pulse(1, 0);
    chk("fill_p", 32'(bus.p_count), 32'd7);
    chk("fill_full", 32'(bus.full_flag), 32'd1);
    chk("fill_erej", 32'(n_erej - base_e), 32'd1);
    sb.push_back(wt_model(7, 3));
    wait_result("wt_p7_t3");
    base_e = n_erej;
    base_l = n_lrej;
    cell_pulse(1, 1);
    step(2);
    chk("both_p", 32'(bus.p_count), 32'd7);
    chk("both_rej", 32'((n_erej - base_e) + (n_lrej - base_l)), 32'd0);

    // Drain to zero; ZERO path settles two edges after the last decrement
    repeat (6) cell_pulse(0, 1);
    bus.leaving_cell = 1'b0;
    step(2);
    bus.leaving_cell = 1'b1;
    step(1);
    chk("last_dec_p", 32'(bus.p_count), 32'd0);
    chk("last_dec_empty", 32'(bus.empty_flag), 32'd1);
    chk("last_dec_full", 32'(bus.full_flag), 32'd0);
    step(1);
    chk("zero_wtv_e1", 32'(bus.wt_valid), 32'd0);
    step(1);
    chk("zero_wtv_e2", 32'(bus.wt_valid), 32'd1);
    sb.push_back(32'd0);
    wait_result("wt_p0");
    base_l = n_lrej;
    cell_pulse(0, 1);
    step(1);
    chk("under_p", 32'(bus.p_count), 32'd0);
    chk("under_lrej", 32'(n_lrej - base_l), 32'd1);
`ifdef SBQM_REJECT_CNT_EN
    chk("rej_leave_cnt", 32'(bus.rej_leave_cnt), 32'd1);
    chk("rej_enter_cnt", 32'(bus.rej_enter_cnt), 32'd1);
`endif

    // Operand churn during CALC: only the final pair may produce a result
    bus.t_count = 2'd1;
    repeat (2) cell_pulse(1, 0);
    sb.push_back(wt_model(2, 1));
    wait_result("wt_p2_t1");
    bus.t_count = 2'd2; step(3);
    chk("churn_a_wtv", 32'(bus.wt_valid), 32'd0);
    chk("churn_a_hold", 32'(bus.waiting_time), 32'd6);
    bus.t_count = 2'd3; step(3);
    chk("churn_b_wtv", 32'(bus.wt_valid), 32'd0);
    bus.t_count = 2'd0; step(3);
    chk("churn_c_wtv", 32'(bus.wt_valid), 32'd0);
    chk("churn_c_hold", 32'(bus.waiting_time), 32'd6);
    bus.t_count = 2'd2; step(3);
    chk("churn_d_wtv", 32'(bus.wt_valid), 32'd0);
    bus.t_count = 2'd3;
    sb.push_back(wt_model(2, 3));
    wait_result("wt_p2_t3");

    // Reset in the middle of a calculation
    bus.t_count = 2'd1;
    step(4);
    chk("midcalc_wtv", 32'(bus.wt_valid), 32'd0);
    reset = 1'b1;
    step(1);
    chk_reset_state("midrst");
    reset = 1'b0;
    step(12);
    chk_reset_state("postrst");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
